// File: rtl/uart_line_conditioner_pkg.sv
// Shared word type and auto-baud definitions for the UART line conditioner.
package Types_pkg;
  typedef logic [31:0] word_t;
  localparam word_t WORD_MAX = 32'hFFFF_FFFF;
endpackage

package UART_pkg;
  import Types_pkg::*;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_IDLE = 3'd1,
    WAIT_FALL = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } autobaud_state_t;

  localparam word_t AUTOBAUD_COUNT_MAX = WORD_MAX;
endpackage

// File: rtl/uart_line_conditioner_sync_filter.sv
// Metastability synchroniser followed by a majority-free glitch filter:
// rx only moves once the whole sample window agrees.
module sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_pin,
  output logic rx
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILTER_LEN-1:0]  win_q;
  logic [FILTER_LEN-1:0]  win_d;
  logic                   rx_q;
  logic                   rx_d;

  // The decision looks at the window including the sample being shifted in,
  // so a stable change reaches rx after SYNC_STAGES + FILTER_LEN edges.
  always_comb begin
    win_d    = win_q;
    win_d[0] = sync_q[SYNC_STAGES-1];
    for (int i = 1; i < FILTER_LEN; i++) begin
      win_d[i] = win_q[i-1];
    end
    rx_d = rx_q;
    if (&win_d) begin
      rx_d = 1'b1;
    end else if (~|win_d) begin
      rx_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      win_q  <= '1;
      rx_q   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
      win_q  <= win_d;
      rx_q   <= rx_d;
    end
  end

  assign rx = rx_q;
endmodule

// File: rtl/uart_line_conditioner.sv
// UART pin conditioner: sync/filter, break detector and start-bit auto-baud.
// States: IDLE wait for start | WAIT_IDLE wait line high | WAIT_FALL wait start edge | MEASURE count low | DONE report
module uart_line_conditioner
  import Types_pkg::*;
  import UART_pkg::*;
#(
  parameter int    SYNC_STAGES      = 2,
  parameter int    FILTER_LEN       = 3,
  parameter int    MIN_BIT_CYCLES   = 4,
  parameter word_t DEFAULT_DIVISION = 32'd0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  rx_pin,
  output logic  rx,
  input  word_t break_threshold,
  output logic  break_detected,
  input  logic  autobaud_start,
  output logic  autobaud_busy,
  output logic  autobaud_done,
  output logic  autobaud_error,
  output word_t division
);
  autobaud_state_t state_q;
  word_t           count_q;
  word_t           division_q;
  word_t           brk_cnt_q;
  word_t           brk_cnt_d;
  logic            busy_q;
  logic            done_q;
  logic            error_q;

  sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .clk   (clk),
    .reset (reset),
    .rx_pin(rx_pin),
    .rx    (rx)
  );

  // brk_cnt_d counts the current low cycle too, so the flag is up during the
  // threshold-th low cycle and falls in the very cycle rx returns high.
  always_comb begin
    brk_cnt_d = '0;
    if (!rx) begin
      brk_cnt_d = (brk_cnt_q == WORD_MAX) ? brk_cnt_q : brk_cnt_q + 32'd1;
    end
  end

  assign break_detected = (break_threshold != '0) && (brk_cnt_d >= break_threshold);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brk_cnt_q <= '0;
    end else begin
      brk_cnt_q <= brk_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      division_q <= DEFAULT_DIVISION;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (autobaud_start) begin
            state_q <= WAIT_IDLE;
            busy_q  <= 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx) begin
            state_q <= WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          if (!rx) begin
            count_q <= 32'd1;
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (rx) begin
            // UART spends division+1 clocks per bit, hence count-1
            if (count_q < word_t'(MIN_BIT_CYCLES)) begin
              error_q <= 1'b1;
            end else begin
              division_q <= count_q - 32'd1;
              error_q    <= 1'b0;
            end
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (break_detected || (count_q == AUTOBAUD_COUNT_MAX)) begin
            error_q <= 1'b1;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            count_q <= count_q + 32'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign autobaud_busy  = busy_q;
  assign autobaud_done  = done_q;
  assign autobaud_error = error_q;
  assign division       = division_q;
endmodule

// File: tb/tb_uart_line_conditioner.sv
// Directed bench: autobaud results go through a scoreboard queue checked by a
// monitor on autobaud_done; line and break behaviour are checked inline.
module tb_uart_line_conditioner;
  logic        clk = 1'b0;
  logic        reset;
  logic        rx_pin;
  logic        rx;
  logic [31:0] break_threshold;
  logic        break_detected;
  logic        autobaud_start;
  logic        autobaud_busy;
  logic        autobaud_done;
  logic        autobaud_error;
  logic [31:0] division;

  typedef struct packed {
    logic        err;
    logic [31:0] div;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  uart_line_conditioner dut (
    .clk            (clk),
    .reset          (reset),
    .rx_pin         (rx_pin),
    .rx             (rx),
    .break_threshold(break_threshold),
    .break_detected (break_detected),
    .autobaud_start (autobaud_start),
    .autobaud_busy  (autobaud_busy),
    .autobaud_done  (autobaud_done),
    .autobaud_error (autobaud_error),
    .division       (division)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    autobaud_start = 1'b1;
    @(negedge clk);
    autobaud_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int bitlen);
    rx_pin = 1'b0;
    cycles(bitlen);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      cycles(bitlen);
    end
    rx_pin = 1'b1;
    cycles(bitlen);
  endtask

  // Pin low for len clocks; returns how many samples of rx were low afterwards.
  task automatic glitch(input int len, output int lows);
    lows = 0;
    rx_pin = 1'b0;
    for (int i = 0; i < len + 12; i++) begin
      @(negedge clk);
      if (!rx) lows++;
      if (i == len - 1) rx_pin = 1'b1;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (autobaud_done === 1'b1) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_done actual=done required=no_done");
        end else begin
          e = sb_q.pop_front();
          chk("ab_error", {31'd0, autobaud_error}, {31'd0, e.err});
          chk("ab_division", division, e.div);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int lows;
    int lowrun;
    int rise_at;
    int brk_bad;

    reset = 1'b1;
    rx_pin = 1'b0;
    break_threshold = 32'd0;
    autobaud_start = 1'b0;
    cycles(4);
    chk("reset_rx", {31'd0, rx}, 32'd1);
    chk("reset_division", division, 32'd0);
    chk("reset_break", {31'd0, break_detected}, 32'd0);
    chk("reset_busy", {31'd0, autobaud_busy}, 32'd0);

    reset = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!rx && n == 0) n = i;
    end
    chk("rx_latency", n, 5);

    rx_pin = 1'b1;
    cycles(12);
    glitch(1, lows);
    chk("glitch1_lows", lows, 0);
    glitch(2, lows);
    chk("glitch2_lows", lows, 0);
    glitch(3, lows);
    chk("pulse3_lows", lows, 3);

    // 0x55 at 100 clocks/bit
    sb_q.push_back('{err: 1'b0, div: 32'd99});
    pulse_start();
    chk("busy_after_start", {31'd0, autobaud_busy}, 32'd1);
    send_byte(8'h55, 100);
    cycles(20);

    // 3-clock start bit is below the minimum bit width
    sb_q.push_back('{err: 1'b1, div: 32'd99});
    pulse_start();
    cycles(3);
    glitch(3, lows);
    cycles(20);
    chk("division_kept", division, 32'd99);

    // Break without measurement
    break_threshold = 32'd50;
    rx_pin = 1'b0;
    lowrun = 0;
    rise_at = 0;
    brk_bad = 0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (!rx) lowrun++;
      else lowrun = 0;
      if (break_detected !== (lowrun >= 50)) brk_bad++;
      if (break_detected && rise_at == 0) rise_at = lowrun;
      if (i == 59) rx_pin = 1'b1;
    end
    chk("break_rise_cycle", rise_at, 50);
    chk("break_track", brk_bad, 0);

    // Break during a measurement aborts it
    sb_q.push_back('{err: 1'b1, div: 32'd99});
    pulse_start();
    cycles(3);
    rx_pin = 1'b0;
    cycles(60);
    rx_pin = 1'b1;
    cycles(40);

    // Asynchronous reset while in MEASURE
    break_threshold = 32'd0;
    pulse_start();
    cycles(3);
    rx_pin = 1'b0;
    cycles(20);
    chk("busy_in_measure", {31'd0, autobaud_busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, autobaud_busy}, 32'd0);
    chk("arst_done", {31'd0, autobaud_done}, 32'd0);
    chk("arst_error", {31'd0, autobaud_error}, 32'd0);
    chk("arst_break", {31'd0, break_detected}, 32'd0);
    chk("arst_division", division, 32'd0);
    chk("arst_rx", {31'd0, rx}, 32'd1);
    rx_pin = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cycles(10);

    sb_q.push_back('{err: 1'b0, div: 32'd63});
    pulse_start();
    send_byte(8'h55, 64);
    cycles(30);

    chk("sb_empty", sb_q.size(), 0);
    chk("done_count", done_cnt, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_line_conditioner.md
# uart_line_conditioner

Front-end stage between the external serial pin and the UART receiver. It synchronises the asynchronous `rx_pin`, removes short glitches and drives the conditioned `rx` into the UART's `rx` input. It also detects line breaks. An auto-baud engine measures a received start bit and produces a `division` value in the UART's division-register format, so software can copy it into the UART.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flops in the metastability synchroniser; minimum 2.
- `FILTER_LEN`, 3: sample-window length of the glitch filter; minimum 1.
- `MIN_BIT_CYCLES`, 4: shortest accepted measured bit, in clocks.
- `DEFAULT_DIVISION`, 32'd0: reset value of `division`.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high. Resets every register.
- `rx_pin` in 1: raw serial input, asynchronous to `clk`.
- `rx` out 1: conditioned line, connected to the UART `rx` input.
- `break_threshold` in 32: consecutive low clocks that define a break. 0 disables break detection.
- `break_detected` out 1: level signal, asserted while a break is in progress.
- `autobaud_start` in 1: one-cycle request to arm a measurement.
- `autobaud_busy` out 1: high while a measurement is armed or running.
- `autobaud_done` out 1: one-cycle pulse when a measurement ends.
- `autobaud_error` out 1: valid on `autobaud_done`; 1 means the measurement was rejected.
- `division` out 32: most recent accepted measurement.

## Operation
Synchroniser:
- `rx_pin` shifts through `SYNC_STAGES` flip-flops. The reset value of every stage is 1 (idle line).
- All logic downstream uses only the last stage.

Glitch filter:
- A window holds the last `FILTER_LEN` synchronised samples. Reset value is all ones.
- `rx` changes to v only when every sample in the window equals v. Otherwise `rx` holds its value.
- Reset value of `rx` is 1.
- Any low or high excursion shorter than `FILTER_LEN` clocks never reaches `rx`.

Break detector:
- A saturating 32-bit counter increments on every clock where `rx` is 0 and clears when `rx` is 1.
- `break_detected` is 1 when `break_threshold != 0` and the counter is ≥ `break_threshold`.
- `break_detected` drops on the first cycle `rx` is 1.
- Reset value of `break_detected` is 0.

Auto-baud FSM, states `IDLE`, `WAIT_IDLE`, `WAIT_FALL`, `MEASURE`, `DONE`:
- `IDLE`: on `autobaud_start`, go to `WAIT_IDLE`. `autobaud_start` is ignored in every other state.
- `WAIT_IDLE`: go to `WAIT_FALL` when `rx` = 1.
- `WAIT_FALL`: when `rx` = 0, set count to 1 and go to `MEASURE`.
- `MEASURE`, each cycle with `rx` = 0: increment count, saturating at 32'hFFFF_FFFF.
- `MEASURE` abort: if `break_detected` or count saturates, set error = 1 and go to `DONE`.
- `MEASURE`, on `rx` = 1:
  - If count < `MIN_BIT_CYCLES`: error = 1.
  - Otherwise: `division` ← count − 1 and error = 0.
  - Go to `DONE`.
- `DONE`: `autobaud_done` = 1 for this one cycle, then go to `IDLE`.
- `autobaud_busy` = 1 in `WAIT_IDLE`, `WAIT_FALL` and `MEASURE`.
- On error, `division` keeps its previous value.
- The measured character must start with a single-bit start bit followed by a 1 data bit; 0x55 is the standard choice.
- `count − 1` is correct because the UART spends division+1 clocks per bit.

## Timing
- Pin to `rx` latency is exactly `SYNC_STAGES + FILTER_LEN` clock edges for a change that stays stable. With defaults this is 5.
- The FSM sees `rx`, so the measured width equals the filtered low width. Filter latency cancels because both edges are delayed equally.
- `division` updates on the same edge as the `MEASURE`→`DONE` transition, so it is valid while `autobaud_done` = 1.
- `break_detected` rises on the edge where the counter reaches `break_threshold`.
- `autobaud_start` arriving on the same cycle as `autobaud_done` is ignored.
- Asynchronous reset at any point, including mid-measurement:
  - FSM returns to `IDLE`.
  - `autobaud_busy`, `autobaud_done`, `autobaud_error` and `break_detected` go to 0.
  - `division` = `DEFAULT_DIVISION`.
  - `rx` and all sync/window stages = 1.
  - Break counter = 0.

## Structure
- `UART_pkg` gets:
  - the `autobaud_state_t` enum;
  - constant `AUTOBAUD_COUNT_MAX`.
- `word_t` comes from `Types_pkg`.
- One sub-module, `sync_filter`, contains the synchroniser and glitch filter. It takes `SYNC_STAGES` and `FILTER_LEN` and outputs `rx`.
- Break detection and the auto-baud FSM are in the top module.

## Test plan
- Reset with `rx_pin` = 0 → `rx` = 1 and `division` = `DEFAULT_DIVISION` until release. After release, `rx` falls exactly 5 edges later.
- Low glitches of 1 and 2 clocks on `rx_pin` (defaults) → `rx` stays 1. A 3-clock low → `rx` low for 3 clocks.
- `autobaud_start`, then a 0x55 frame at 100 clocks/bit → `autobaud_busy` high; `autobaud_done` pulse with error 0; `division` = 99.
- `autobaud_start`, then a 3-clock-wide start bit (`FILTER_LEN` = 3, `MIN_BIT_CYCLES` = 4) → `autobaud_done` with error 1; `division` unchanged.
- `break_threshold` = 50, line held low for 60 clocks → `break_detected` rises on the 50th low cycle of `rx` and falls the cycle `rx` returns to 1. With an active measurement, the result is error 1.
- Assert `reset` while in `MEASURE` → all outputs return to their reset values immediately, without waiting for a clock edge. A fresh 0x55 measurement afterwards succeeds.
